l2_return_router: RTL and testbench
===================================

# l2_return_router

Memory-side read-return stage of the L2 arbiter. It consumes one data-attribute entry per memory read (`l2_data_attributes_t`: port id, burst size, abort flag) and the memory read-return beats (`l2_mem_return_data_t`). It then steers each beat into a per-port return FIFO as `l2_return_data_t`, or discards the whole burst when it is aborted. It sits between the memory read-data interface and the per-port read-return channels.

## Interface
Parameters:
- `RETURN_DEPTH`, default 2: entries per port return FIFO; power of two, ≥2.

Ports (`NP = L2_NUM_PORTS`):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `attr_valid`  in  1  data-attribute FIFO not empty.
- `attr`  in  `l2_data_attributes_t`  head entry: `id`, `burst_size`, `abort`.
- `attr_pop`  out  1  pops the attribute entry; one-cycle pulse.
- `mem_rd_valid`  in  1  memory return beat valid.
- `mem_rd`  in  `l2_mem_return_data_t`  beat: `id`, `sub_id`, `data`.
- `mem_rd_ready`  out  1  beat accepted when `mem_rd_valid & mem_rd_ready`.
- `port_rd_valid`  out  NP  per-port return FIFO not empty.
- `port_rd`  out  NP × `l2_return_data_t`  per-port FIFO head.
- `port_rd_ack`  in  NP  per-port pop; ignored when the matching valid is 0.
- `id_mismatch`  out  1  sticky error flag.

## Operation
- The control FSM has three states: IDLE, BURST and DISCARD.
- **IDLE**
  - `mem_rd_ready=0`.
  - If `attr_valid`: assert `attr_pop`, latch `cur_id=attr.id` and `remaining=attr.burst_size`.
  - Next state is DISCARD if `attr.abort`, otherwise BURST.
- **Burst length:** a burst is `burst_size+1` beats (1–32). `remaining` is 5 bits and holds the beats left minus one.
- **BURST**
  - `mem_rd_ready = !full[cur_id]`.
  - On an accepted beat, push `{mem_rd.sub_id, mem_rd.data}` into FIFO `cur_id`.
  - If `remaining==0`, go to IDLE; otherwise decrement `remaining`.
- **DISCARD**
  - `mem_rd_ready=1`.
  - Accepted beats are dropped and counted the same way as in BURST.
  - Go to IDLE after the final beat.
- **ID check:** on any beat accepted in BURST, if `mem_rd.id != cur_id`, set `id_mismatch`. The flag stays set until reset. The beat is still routed to `cur_id`.
- **Port FIFOs:** each port has an independent FIFO.
  - Push and pop in the same cycle on a full FIFO are legal; count is unchanged.
  - Push and pop in the same cycle on an empty FIFO are not a bypass unless the macro below is defined.
- **Boundaries:**
  - A beat arriving in IDLE is never accepted.
  - A full destination FIFO stalls only the memory side. Other ports still drain.
  - `attr_valid` while in BURST or DISCARD is ignored until IDLE.
- **Reset mid-burst:** the FSM returns to IDLE, all FIFOs empty, `remaining=0` and `id_mismatch=0`. The attribute entry of the in-flight burst is lost; recovery is the system's responsibility.

## Timing
- **Reset values:** `attr_pop=0`, `mem_rd_ready=0`, `port_rd_valid=0`, `port_rd=0`, `id_mismatch=0`.
- **Per-burst overhead:** one IDLE cycle per burst (attribute pop). Back-to-back bursts therefore lose one cycle each.
- **Beat-to-port latency:** an accepted beat at edge N sets `port_rd_valid` after edge N, so it is visible in cycle N+1.
- **Throughput:** one beat per cycle while the destination FIFO has space.
- **Ready timing:**
  - `mem_rd_ready` is combinational from state and registered FIFO full flags only. It never depends on `mem_rd_valid`.
  - A pop at edge N makes a full FIFO not full in cycle N+1. A same-cycle `port_rd_ack` does not raise `mem_rd_ready` (no combinational ack→ready path).
- **Attribute pop:** `attr_pop` is combinational: `IDLE & attr_valid`.

## Configuration
- **`L2_RETURN_BYPASS_EN` defined:** when port p's FIFO is empty, state is BURST, `cur_id==p` and a beat is accepted, the beat is presented on `port_rd[p]` / `port_rd_valid[p]` in the same cycle. If `port_rd_ack[p]` is also high that cycle, the beat is consumed and not written.
- **Undefined:** strictly registered, one-cycle latency as above.

## Structure
- **Package additions (`l2_config_and_types`):** `L2_RETURN_FIFO_DEPTH` (default for `RETURN_DEPTH`) and the FSM enum `l2_return_state_t` {IDLE, BURST, DISCARD}.
- **Sub-module:** `l2_return_fifo`, a single-port-id FIFO of `l2_return_data_t` with registered `full`/`valid`. It is instantiated NP times via generate; the bypass logic lives in the sub-module.
- **Top level:** holds the FSM, burst counter, id check and push demux.

## Test plan
- Attribute {id=1, burst_size=3, abort=0}, four beats back-to-back → port 1 emits the four data words in order; port 0 stays idle; `attr_pop` pulses once; returns to IDLE after beat 4.
- Attribute {id=0, burst_size=7, abort=1}, eight beats → all accepted with `mem_rd_ready=1`; no `port_rd_valid`; next attribute is popped afterwards.
- Port 0, `RETURN_DEPTH=2`, no ack, burst_size=4 → `mem_rd_ready` drops after 2 beats. Ack once → exactly one more beat accepted, no earlier than the cycle after the ack.
- Burst for `cur_id=1` with one beat carrying `mem_rd.id=0` → `id_mismatch` rises the next cycle and stays high; the word appears on port 1.
- Assert `rst` low mid-burst (after 2 of 4 beats) → all outputs at reset values immediately; after release, a new attribute processes normally.
- With `L2_RETURN_BYPASS_EN`, empty FIFO and port ack held high, 1-beat burst → `port_rd_valid` in the accept cycle; FIFO remains empty.

Source files
------------

// File: rtl/l2_return_router_pkg.sv
// Shared types and constants for the L2 read-return path.
// Holds the port count, the attribute / memory-beat / return-word structs,
// the return FIFO default depth and the return-router FSM state enum.
package l2_config_and_types;

  localparam int L2_NUM_PORTS         = 4;
  localparam int L2_PORT_ID_W         = $clog2(L2_NUM_PORTS);
  localparam int L2_SUB_ID_W          = 4;
  localparam int L2_DATA_W            = 32;
  localparam int L2_BURST_W           = 5;   // burst_size + 1 gives 1..32 beats
  localparam int L2_RETURN_FIFO_DEPTH = 2;   // default RETURN_DEPTH

  typedef logic [L2_PORT_ID_W-1:0] l2_port_id_t;

  // One entry per memory read, popped before its beats are routed.
  typedef struct packed {
    l2_port_id_t            id;
    logic [L2_BURST_W-1:0]  burst_size;
    logic                   abort;
  } l2_data_attributes_t;

  // One memory read-return beat.
  typedef struct packed {
    l2_port_id_t            id;
    logic [L2_SUB_ID_W-1:0] sub_id;
    logic [L2_DATA_W-1:0]   data;
  } l2_mem_return_data_t;

  // Word delivered on a per-port return channel.
  typedef struct packed {
    logic [L2_SUB_ID_W-1:0] sub_id;
    logic [L2_DATA_W-1:0]   data;
  } l2_return_data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    DISCARD = 2'd2
  } l2_return_state_t;

  // Strip the routing id from a memory beat to form the port return word.
  function automatic l2_return_data_t l2_to_return(input l2_mem_return_data_t beat);
    l2_return_data_t r;
    r.sub_id = beat.sub_id;
    r.data   = beat.data;
    return r;
  endfunction

endpackage

// File: rtl/l2_return_router_fifo.sv
// l2_return_fifo: return FIFO for a single port id.
// full and valid come from registers so the router's ready never sees a
// combinational path from port_rd_ack.
// Optional macro L2_RETURN_BYPASS_EN: when the FIFO is empty, a pushed word is
// presented on head/valid in the same cycle, and if pop is also high it is
// consumed without being written.
module l2_return_fifo
  import l2_config_and_types::*;
#(
  parameter int DEPTH = L2_RETURN_FIFO_DEPTH   // power of two, >= 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  l2_return_data_t push_data,
  input  logic            pop,
  output logic            full,
  output logic            valid,
  output l2_return_data_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  l2_return_data_t r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_valid;

  logic            w_bypass;
  logic            w_write;
  logic            w_read;
  logic [CW-1:0]   w_count_nxt;

`ifdef L2_RETURN_BYPASS_EN
  assign w_bypass = push & ~r_valid & pop;
  assign valid    = r_valid | push;
  assign head     = r_valid ? r_mem[r_rd_ptr] : (push ? push_data : '0);
`else
  assign w_bypass = 1'b0;
  assign valid    = r_valid;
  assign head     = r_valid ? r_mem[r_rd_ptr] : '0;
`endif

  // A pop on an empty FIFO is ignored; push on full is only legal with a pop.
  assign w_read      = pop & r_valid;
  assign w_write     = push & ~w_bypass & (~r_full | w_read);
  assign w_count_nxt = r_count + CW'(w_write) - CW'(w_read);
  assign full        = r_full;

  // Pointers, occupancy and the registered full/valid flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_read)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_valid <= (w_count_nxt != '0);
    end
  end

  // Storage; head is gated by valid, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/l2_return_router.sv
// l2_return_router: steers memory read-return beats into per-port return
// FIFOs using one data-attribute entry per burst, or drops aborted bursts.
// FSM: IDLE pops an attribute, BURST routes beats to cur_id, DISCARD drops.
// Optional macro L2_RETURN_BYPASS_EN enables same-cycle FIFO bypass (inside
// l2_return_fifo).
// Handshakes: a memory beat transfers when mem_rd_valid & mem_rd_ready;
// mem_rd_ready depends only on state and registered FIFO full flags. A port
// word transfers when port_rd_valid[p] & port_rd_ack[p]. attr_pop is a
// one-cycle pulse meaning the head attribute entry was consumed.
module l2_return_router
  import l2_config_and_types::*;
#(
  parameter int RETURN_DEPTH = L2_RETURN_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               attr_valid,
  input  l2_data_attributes_t                attr,
  output logic                               attr_pop,
  input  logic                               mem_rd_valid,
  input  l2_mem_return_data_t                mem_rd,
  output logic                               mem_rd_ready,
  output logic [L2_NUM_PORTS-1:0]            port_rd_valid,
  output l2_return_data_t [L2_NUM_PORTS-1:0] port_rd,
  input  logic [L2_NUM_PORTS-1:0]            port_rd_ack,
  output logic                               id_mismatch,
  output l2_return_state_t                   dbg_state
);

  localparam int NP = L2_NUM_PORTS;

  l2_return_state_t      r_state;
  l2_return_state_t      w_state_nxt;
  l2_port_id_t           r_cur_id;
  logic [L2_BURST_W-1:0] r_remaining;   // beats left minus one
  logic                  r_id_mismatch;

  logic                  w_accept;
  logic                  w_routed;
  logic [NP-1:0]         w_push;
  logic [NP-1:0]         w_full;
  l2_return_data_t       w_push_data;

  assign w_accept    = mem_rd_valid & mem_rd_ready;
  assign w_routed    = w_accept & (r_state == BURST);
  assign w_push_data = l2_to_return(mem_rd);
  assign id_mismatch = r_id_mismatch;
  assign dbg_state   = r_state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state: leave IDLE on an attribute, return after the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (attr_valid) w_state_nxt = attr.abort ? DISCARD : BURST;
      end
      BURST, DISCARD: begin
        if (w_accept && (r_remaining == '0)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: attribute pop in IDLE, ready from the destination full flag.
  always_comb begin
    attr_pop     = 1'b0;
    mem_rd_ready = 1'b0;
    case (r_state)
      IDLE:    attr_pop     = attr_valid;
      BURST:   mem_rd_ready = ~w_full[r_cur_id];
      DISCARD: mem_rd_ready = 1'b1;
      default: mem_rd_ready = 1'b0;
    endcase
  end

  // Burst destination and beat counter, loaded on the attribute pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_id    <= '0;
      r_remaining <= '0;
    end else if (attr_pop) begin
      r_cur_id    <= attr.id;
      r_remaining <= attr.burst_size;
    end else if (w_accept && (r_remaining != '0)) begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  // Sticky flag: a routed beat whose id disagrees with the attribute id.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_mismatch <= 1'b0;
    end else if (w_routed && (mem_rd.id != r_cur_id)) begin
      r_id_mismatch <= 1'b1;
    end
  end

  // Push demux plus one return FIFO per port; a mismatched beat still goes to cur_id.
  for (genvar p = 0; p < NP; p++) begin : g_port
    assign w_push[p] = w_routed & (r_cur_id == l2_port_id_t'(p));

    l2_return_fifo #(
      .DEPTH(RETURN_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push[p]),
      .push_data(w_push_data),
      .pop      (port_rd_ack[p]),
      .full     (w_full[p]),
      .valid    (port_rd_valid[p]),
      .head     (port_rd[p])
    );
  end

endmodule

// File: tb/tb_l2_return_router.sv
// Testbench for l2_return_router: directed scenarios followed by random bursts.
// The driver pushes each accepted, non-aborted beat onto the expected queue of
// its destination port; a monitor pops and compares on every port transfer.
module tb_l2_return_router;
  import l2_config_and_types::*;

  localparam int NP    = L2_NUM_PORTS;
  localparam int DEPTH = L2_RETURN_FIFO_DEPTH;
  localparam int RW    = $bits(l2_return_data_t);

  // ---------------- clock / reset / DUT ----------------
  logic                      clk = 1'b0;
  logic                      rst;
  logic                      attr_valid;
  l2_data_attributes_t       attr;
  logic                      attr_pop;
  logic                      mem_rd_valid;
  l2_mem_return_data_t       mem_rd;
  logic                      mem_rd_ready;
  logic [NP-1:0]             port_rd_valid;
  l2_return_data_t [NP-1:0]  port_rd;
  logic [NP-1:0]             port_rd_ack;
  logic                      id_mismatch;
  l2_return_state_t          dbg_state;

  always #5 clk = ~clk;

  l2_return_router #(.RETURN_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .attr_valid(attr_valid), .attr(attr), .attr_pop(attr_pop),
    .mem_rd_valid(mem_rd_valid), .mem_rd(mem_rd), .mem_rd_ready(mem_rd_ready),
    .port_rd_valid(port_rd_valid), .port_rd(port_rd), .port_rd_ack(port_rd_ack),
    .id_mismatch(id_mismatch), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q [NP][$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            exp_mm = 0;       // model of the sticky id flag
  int            beats_acc = 0;
  int            pops_seen = 0;
  int            pops_exp = 0;
  bit            ack_random = 1'b1;
  logic [NP-1:0] ack_manual = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- port ack driver ----------------
  initial begin
    port_rd_ack = '0;
    forever begin
      @(posedge clk); #1;
      port_rd_ack = ack_random ? NP'($urandom) : ack_manual;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        if (attr_pop) pops_seen++;
        for (int p = 0; p < NP; p++) begin
          if (port_rd_valid[p]) begin
            if (exp_q[p].size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL port_valid_unexpected: port %0d got valid 1 expected 0 at %0t", p, $time);
            end else if (port_rd_ack[p]) begin
              logic [RW-1:0] e;
              e = exp_q[p].pop_front();
              check($sformatf("port%0d_data", p), 64'(port_rd[p]), 64'(e));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int dst, input bit discard, input bit bad, input int sub, output bit ok);
    int budget;
    l2_return_data_t rd;
    budget       = 0;
    ok           = 0;
    mem_rd_valid = 1'b1;
    mem_rd.id     = l2_port_id_t'(bad ? (dst ^ 1) : dst);
    mem_rd.sub_id = L2_SUB_ID_W'(sub);
    mem_rd.data   = $urandom;
    while (!ok && budget < 200) begin
      @(negedge clk);
      budget++;
      if (discard) check("ready_discard", 64'(mem_rd_ready), 64'd1);
      if (mem_rd_ready) begin
        ok = 1;
        beats_acc++;
        if (!discard) begin
          rd.sub_id = mem_rd.sub_id;
          rd.data   = mem_rd.data;
          exp_q[dst].push_back(rd);
          if (bad) exp_mm = 1;
        end
      end
      @(posedge clk); #1;
    end
    mem_rd_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL beat_timeout: port %0d beat %0d got no ready expected accept", dst, sub);
    end else begin
      check("id_mismatch", 64'(id_mismatch), 64'(exp_mm));
    end
  endtask

  task automatic wait_attr_pop();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!attr_pop && budget < 100);
    if (!attr_pop) begin
      n_cmp++; n_err++;
      $display("FAIL attr_pop_timeout: got 0 expected 1");
    end else begin
      check("ready_in_idle", 64'(mem_rd_ready), 64'd0);
    end
    pops_exp++;
    @(posedge clk); #1;
    attr_valid = 1'b0;
  endtask

  task automatic run_burst(input int id, input int bs, input bit abort, input int bad_beat, input bit gaps);
    bit ok;
    attr_valid      = 1'b1;
    attr.id         = l2_port_id_t'(id);
    attr.burst_size = L2_BURST_W'(bs);
    attr.abort      = abort;
    wait_attr_pop();
    for (int b = 0; b <= bs; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_beat(id, abort, (b == bad_beat), b, ok);
    end
    check("idle_after_burst", 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int budget;
    rst          = 1'b0;
    attr_valid   = 1'b0;
    attr         = '0;
    mem_rd_valid = 1'b0;
    mem_rd       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_attr_pop",  64'(attr_pop), 64'd0);
    check("rst_ready",     64'(mem_rd_ready), 64'd0);
    check("rst_port_valid", 64'(port_rd_valid), 64'd0);
    check("rst_port_rd",   64'(port_rd), 64'd0);
    check("rst_id_mm",     64'(id_mismatch), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Four-beat burst to port 1, back-to-back.
    run_burst(1, 3, 0, -1, 0);
    check("port0_idle", 64'(port_rd_valid[0]), 64'd0);

    // A beat presented in IDLE is never accepted.
    mem_rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_idle_beat", 64'(mem_rd_ready), 64'd0);
    end
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;

    // Aborted eight-beat burst, then a normal burst afterwards.
    run_burst(0, 7, 1, -1, 0);
    run_burst(2, 1, 0, -1, 0);

    // Backpressure: port 0 fills after two beats; one ack frees one slot.
    repeat (10) @(posedge clk);
    #1;
    ack_random = 1'b0;
    ack_manual = '0;
    beats_acc  = 0;
    fork
      run_burst(0, 4, 0, -1, 0);
      begin
        budget = 0;
        do begin
          @(negedge clk); #2;
          budget++;
        end while (beats_acc < 2 && budget < 100);
        @(negedge clk); #2;
        check("ready_full", 64'(mem_rd_ready), 64'd0);
        @(negedge clk); #2;
        check("ready_full_hold", 64'(mem_rd_ready), 64'd0);
        check("beats_before_ack", 64'(beats_acc), 64'd2);
        ack_manual[0] = 1'b1;
        @(negedge clk); #2;
        check("no_ack_to_ready", 64'(mem_rd_ready), 64'd0);
        check("no_early_accept", 64'(beats_acc), 64'd2);
        ack_manual[0] = 1'b0;
        @(negedge clk); #2;
        check("ready_after_pop", 64'(mem_rd_ready), 64'd1);
        check("one_more_beat", 64'(beats_acc), 64'd3);
        @(negedge clk); #2;
        check("ready_full_again", 64'(mem_rd_ready), 64'd0);
        check("beats_after_ack", 64'(beats_acc), 64'd3);
        ack_random = 1'b1;
      end
    join

    // Id mismatch on beat 1 of a port-1 burst; the word still lands on port 1.
    run_burst(1, 3, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("id_mm_sticky", 64'(id_mismatch), 64'd1);

    // Reset in the middle of a four-beat burst.
    attr_valid = 1'b1;
    attr.id = 2'd2; attr.burst_size = 5'd3; attr.abort = 1'b0;
    wait_attr_pop();
    send_beat(2, 0, 0, 0, ok);
    send_beat(2, 0, 0, 1, ok);
    mem_rd_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_attr_pop", 64'(attr_pop), 64'd0);
    check("mid_rst_ready",   64'(mem_rd_ready), 64'd0);
    check("mid_rst_valid",   64'(port_rd_valid), 64'd0);
    check("mid_rst_port_rd", 64'(port_rd), 64'd0);
    check("mid_rst_id_mm",   64'(id_mismatch), 64'd0);
    mem_rd_valid = 1'b0;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    exp_mm = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    run_burst(2, 3, 0, -1, 0);

`ifdef L2_RETURN_BYPASS_EN
    // Bypass: empty FIFO with ack held high, one-beat burst.
    repeat (10) @(posedge clk);
    #1;
    ack_random = 1'b0;
    ack_manual = '1;
    attr_valid = 1'b1;
    attr.id = 2'd3; attr.burst_size = 5'd0; attr.abort = 1'b0;
    wait_attr_pop();
    mem_rd_valid = 1'b1;
    mem_rd.id = 2'd3; mem_rd.sub_id = 4'd5; mem_rd.data = $urandom;
    @(negedge clk);
    check("bypass_valid", 64'(port_rd_valid[3]), 64'd1);
    if (mem_rd_ready) exp_q[3].push_back(l2_to_return(mem_rd));
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;
    @(negedge clk);
    check("bypass_fifo_empty", 64'(port_rd_valid[3]), 64'd0);
    ack_random = 1'b1;
`endif

    // Longest burst, then random traffic.
    run_burst(3, 31, 0, -1, 1);
    for (int i = 0; i < 30; i++) begin
      int id, bs, bad;
      bit ab;
      id  = $urandom_range(0, NP - 1);
      bs  = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 31) : $urandom_range(0, 7);
      ab  = ($urandom_range(0, 3) == 0);
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, bs) : -1;
      run_burst(id, bs, ab, bad, 1);
    end

    // Drain everything and close out.
    ack_random = 1'b0;
    ack_manual = '1;
    repeat (3 * DEPTH + 5) @(posedge clk);
    @(negedge clk); #2;
    for (int p = 0; p < NP; p++) check($sformatf("drain_q%0d", p), 64'(exp_q[p].size()), 64'd0);
    check("drain_valid", 64'(port_rd_valid), 64'd0);
    check("attr_pop_count", 64'(pops_seen), 64'(pops_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation got no end expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
